// File: rtl/i2c_config_sequencer_if.sv
// Bus between the power-up register sequencer and its surroundings: the
// external lookup table, the I2C write controller and the status/start lines.
interface i2c_config_sequencer_if #(
  parameter int IDX_W = 4
) ();
  // Handshake: GO low holds the controller in reset (END forced low); GO high
  // runs exactly one transfer, which completes on the first cycle END is seen
  // high while GO is high. ACK is only meaningful alongside END. LUT_DATA is a
  // combinational function of LUT_INDEX.
  logic             START;
  logic [IDX_W-1:0] LUT_INDEX;
  logic [15:0]      LUT_DATA;
  logic [23:0]      I2C_DATA;
  logic             I2C_GO;
  logic             I2C_END;
  logic [2:0]       I2C_ACK;
  logic             BUSY;
  logic             DONE;
  logic             ERROR;
  logic [IDX_W-1:0] ERR_INDEX;
  logic [2:0]       DBG_STATE;

  modport master (
    input  START, LUT_DATA, I2C_END, I2C_ACK,
    output LUT_INDEX, I2C_DATA, I2C_GO, BUSY, DONE, ERROR, ERR_INDEX, DBG_STATE
  );

  modport slave (
    output START, LUT_DATA, I2C_END, I2C_ACK,
    input  LUT_INDEX, I2C_DATA, I2C_GO, BUSY, DONE, ERROR, ERR_INDEX, DBG_STATE
  );
endinterface

// File: rtl/i2c_config_sequencer.sv
// Walks the codec configuration table after reset, issuing one 24-bit I2C
// write per entry with retry on NACK/timeout and sticky DONE/ERROR status.
module i2c_config_sequencer #(
  parameter int         LUT_SIZE      = 11,
  parameter int         IDX_W         = 4,
  parameter logic [7:0] SLAVE_ADDR    = 8'h34,
  parameter int         INIT_DELAY    = 1000,
  parameter int         GO_LOW_CYCLES = 3,
  parameter int         MAX_RETRY     = 3,
  parameter int         XFER_TIMEOUT  = 64
) (
  input  logic                   CLOCK,
  input  logic                   RESET_N,
  i2c_config_sequencer_if.master bus
);

  typedef enum logic [2:0] {
    S_DELAY = 3'd0,
    S_PREP  = 3'd1,
    S_XFER  = 3'd2,
    S_CHECK = 3'd3,
    S_NEXT  = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(LUT_SIZE - 1);
  localparam logic [15:0]      DELAY_LAST = 16'(INIT_DELAY - 1);
  localparam logic [7:0]       GO_LAST    = 8'(GO_LOW_CYCLES - 1);
  localparam logic [15:0]      TO_LAST    = 16'(XFER_TIMEOUT - 1);
  localparam logic [7:0]       RETRY_MAX  = 8'(MAX_RETRY);

  state_t           r_state;
  logic [15:0]      r_delay_cnt;
  logic [7:0]       r_go_cnt;
  logic [15:0]      r_to_cnt;
  logic [7:0]       r_retry_cnt;
  logic             r_timeout;
  logic [IDX_W-1:0] r_lut_index;
  logic [23:0]      r_i2c_data;
  logic             r_i2c_go;
  logic             r_busy;
  logic             r_done;
  logic             r_error;
  logic [IDX_W-1:0] r_err_index;
  logic             w_ack_ok;

  assign w_ack_ok = !r_timeout && (bus.I2C_ACK == 3'b000);

  always_ff @(posedge CLOCK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_state     <= S_DELAY;
      r_delay_cnt <= '0;
      r_go_cnt    <= '0;
      r_to_cnt    <= '0;
      r_retry_cnt <= '0;
      r_timeout   <= 1'b0;
      r_lut_index <= '0;
      r_i2c_data  <= '0;
      r_i2c_go    <= 1'b0;
      r_busy      <= 1'b1;
      r_done      <= 1'b0;
      r_error     <= 1'b0;
      r_err_index <= '0;
    end else begin
      case (r_state)
        S_DELAY: begin
          if (r_delay_cnt == DELAY_LAST) begin
            r_delay_cnt <= '0;
            r_go_cnt    <= '0;
            r_state     <= S_PREP;
          end else begin
            r_delay_cnt <= r_delay_cnt + 16'd1;
          end
        end
        // LUT_INDEX has been stable since entry, so LUT_DATA is settled here.
        S_PREP: begin
          if (r_go_cnt == GO_LAST) begin
            r_go_cnt   <= '0;
            r_i2c_data <= {SLAVE_ADDR, bus.LUT_DATA};
            r_to_cnt   <= '0;
            r_timeout  <= 1'b0;
            r_i2c_go   <= 1'b1;
            r_state    <= S_XFER;
          end else begin
            r_go_cnt <= r_go_cnt + 8'd1;
          end
        end
        S_XFER: begin
          if (bus.I2C_END) begin
            r_state <= S_CHECK;
          end else if (r_to_cnt == TO_LAST) begin
            r_timeout <= 1'b1;
            r_state   <= S_CHECK;
          end else begin
            r_to_cnt <= r_to_cnt + 16'd1;
          end
        end
        S_CHECK: begin
          r_i2c_go <= 1'b0;
          if (w_ack_ok) begin
            r_retry_cnt <= '0;
            r_state     <= S_NEXT;
          end else if (r_retry_cnt < RETRY_MAX) begin
            r_retry_cnt <= r_retry_cnt + 8'd1;
            r_state     <= S_PREP;
          end else begin
            // Only the first exhausted entry is reported; later ones are skipped.
            if (!r_error) r_err_index <= r_lut_index;
            r_error     <= 1'b1;
            r_retry_cnt <= '0;
            r_state     <= S_NEXT;
          end
        end
        S_NEXT: begin
          if (r_lut_index == LAST_IDX) begin
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= S_DONE;
          end else begin
            r_lut_index <= r_lut_index + 1'b1;
            r_state     <= S_PREP;
          end
        end
        S_DONE: begin
          if (bus.START) begin
            r_done      <= 1'b0;
            r_error     <= 1'b0;
            r_err_index <= '0;
            r_lut_index <= '0;
            r_busy      <= 1'b1;
            r_go_cnt    <= '0;
            r_retry_cnt <= '0;
            r_state     <= S_PREP;
          end
        end
        default: r_state <= S_DELAY;
      endcase
    end
  end

  assign bus.LUT_INDEX = r_lut_index;
  assign bus.I2C_DATA  = r_i2c_data;
  assign bus.I2C_GO    = r_i2c_go;
  assign bus.BUSY      = r_busy;
  assign bus.DONE      = r_done;
  assign bus.ERROR     = r_error;
  assign bus.ERR_INDEX = r_err_index;
  assign bus.DBG_STATE = r_state;

endmodule

// File: tb/tb_i2c_config_sequencer.sv
// Directed bench for i2c_config_sequencer: a 4-entry table, a behavioural I2C
// controller with programmable NACK/no-END faults, and per-scenario checks.
module tb_i2c_config_sequencer;

  localparam int LUT_SIZE      = 4;
  localparam int IDX_W         = 4;
  localparam int INIT_DELAY    = 10;
  localparam int GO_LOW_CYCLES = 3;
  localparam int MAX_RETRY     = 3;
  localparam int XFER_TIMEOUT  = 64;
  localparam int END_LAT       = 32;

  // clock / reset
  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  i2c_config_sequencer_if #(.IDX_W(IDX_W)) bus ();

  i2c_config_sequencer #(
    .LUT_SIZE(LUT_SIZE), .IDX_W(IDX_W), .SLAVE_ADDR(8'h34),
    .INIT_DELAY(INIT_DELAY), .GO_LOW_CYCLES(GO_LOW_CYCLES),
    .MAX_RETRY(MAX_RETRY), .XFER_TIMEOUT(XFER_TIMEOUT)
  ) dut (
    .CLOCK(clk),
    .RESET_N(rst_n),
    .bus(bus)
  );

  logic [15:0] lut_tab [16];
  assign bus.LUT_DATA = lut_tab[bus.LUT_INDEX];

  int tests_run    = 0;
  int tests_failed = 0;

  // scoreboard state
  logic [23:0] exp_q[$];
  logic [23:0] att_data[$];
  int          att_idx[$];
  int          att_len[$];
  int          tried[16];

  // controller fault configuration
  int          nack_idx    = -1;
  logic [2:0]  nack_val    = 3'b000;
  bit          nack_always = 1'b0;
  int          noend_idx   = -1;

  function automatic logic [23:0] exp_word(input int i);
    return {8'h34, lut_tab[i]};
  endfunction

  // Behavioural controller, evaluated 1ns after each rising edge.
  initial begin : ctrl_model
    int         cnt;
    bit         was_high;
    int         cur_idx;
    logic [2:0] cur_ack;
    bit         cur_noend;
    cnt = 0; was_high = 1'b0; cur_idx = 0; cur_ack = 3'b000; cur_noend = 1'b0;
    bus.I2C_END = 1'b0;
    bus.I2C_ACK = 3'b111;
    forever begin
      @(posedge clk);
      #1;
      if (bus.I2C_GO) begin
        if (!was_high) begin
          was_high  = 1'b1;
          cnt       = 0;
          cur_idx   = int'(bus.LUT_INDEX);
          att_data.push_back(bus.I2C_DATA);
          att_idx.push_back(cur_idx);
          cur_noend = (cur_idx == noend_idx);
          cur_ack   = (cur_idx == nack_idx && (nack_always || tried[cur_idx] == 0)) ? nack_val : 3'b000;
          tried[cur_idx]++;
        end
        cnt++;
        if (cnt == END_LAT && !cur_noend) begin
          bus.I2C_END = 1'b1;
          bus.I2C_ACK = cur_ack;
        end
      end else begin
        if (was_high) att_len.push_back(cnt);
        was_high    = 1'b0;
        cnt         = 0;
        bus.I2C_END = 1'b0;
        bus.I2C_ACK = 3'b111;
      end
    end
  end

  task automatic clear_logs();
    exp_q.delete();
    att_data.delete();
    att_idx.delete();
    att_len.delete();
    for (int i = 0; i < 16; i++) tried[i] = 0;
  endtask

  task automatic start_run();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    clear_logs();
    rst_n = 1'b1;
  endtask

  task automatic wait_done(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (bus.DONE) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_go(input int budget, output int cyc, output bit seen);
    seen = 1'b0;
    cyc  = 0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      cyc++;
      if (bus.I2C_GO) begin
        seen = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    bus.START = 1'b0;
    #2 rst_n = 1'b0;
    @(negedge clk);
    tests_run++; if (bus.I2C_GO !== 1'b0) begin tests_failed++; $display("FAIL reset_go: got %b expected 0", bus.I2C_GO); end
    tests_run++; if (bus.BUSY !== 1'b1) begin tests_failed++; $display("FAIL reset_busy: got %b expected 1", bus.BUSY); end
    tests_run++; if (bus.DONE !== 1'b0) begin tests_failed++; $display("FAIL reset_done: got %b expected 0", bus.DONE); end
    tests_run++; if (bus.ERROR !== 1'b0) begin tests_failed++; $display("FAIL reset_error: got %b expected 0", bus.ERROR); end
    tests_run++; if (bus.ERR_INDEX !== 4'd0) begin tests_failed++; $display("FAIL reset_err_index: got %0d expected 0", bus.ERR_INDEX); end
    tests_run++; if (bus.LUT_INDEX !== 4'd0) begin tests_failed++; $display("FAIL reset_lut_index: got %0d expected 0", bus.LUT_INDEX); end
    tests_run++; if (bus.I2C_DATA !== 24'h0) begin tests_failed++; $display("FAIL reset_i2c_data: got %h expected 000000", bus.I2C_DATA); end
  endtask

  task automatic test_nominal();
    int cyc;
    bit seen, ok;
    nack_idx = -1; noend_idx = -1;
    clear_logs();
    // START held high through DELAY must not disturb the power-up run.
    bus.START = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    wait_go(200, cyc, seen);
    bus.START = 1'b0;
    tests_run++; if (!seen) begin tests_failed++; $display("FAIL nominal_first_go: got no GO expected GO within 200 cycles"); end
    tests_run++; if (cyc < INIT_DELAY + GO_LOW_CYCLES) begin tests_failed++; $display("FAIL nominal_first_go_time: got %0d expected >= %0d", cyc, INIT_DELAY + GO_LOW_CYCLES); end
    wait_done(2000, ok);
    tests_run++; if (!ok) begin tests_failed++; $display("FAIL nominal_done_timeout: got DONE=0 expected DONE=1 within 2000 cycles"); end
    tests_run++; if (bus.BUSY !== 1'b0) begin tests_failed++; $display("FAIL nominal_busy: got %b expected 0", bus.BUSY); end
    tests_run++; if (bus.ERROR !== 1'b0) begin tests_failed++; $display("FAIL nominal_error: got %b expected 0", bus.ERROR); end
    tests_run++; if (bus.I2C_GO !== 1'b0) begin tests_failed++; $display("FAIL nominal_go_idle: got %b expected 0", bus.I2C_GO); end
    for (int i = 0; i < 4; i++) exp_q.push_back(exp_word(i));
    tests_run++; if (att_data.size() != 4) begin tests_failed++; $display("FAIL nominal_pulses: got %0d expected 4", att_data.size()); end
    for (int i = 0; i < exp_q.size(); i++) begin
      tests_run++; if (att_data[i] !== exp_q[i]) begin tests_failed++; $display("FAIL nominal_data[%0d]: got %h expected %h", i, att_data[i], exp_q[i]); end
      tests_run++; if (att_len[i] != END_LAT + 1) begin tests_failed++; $display("FAIL nominal_go_len[%0d]: got %0d expected %0d", i, att_len[i], END_LAT + 1); end
    end
  endtask

  task automatic test_single_nack();
    bit ok;
    int exp_idx[5];
    exp_idx = '{0, 1, 2, 2, 3};
    nack_idx = 2; nack_val = 3'b010; nack_always = 1'b0; noend_idx = -1;
    start_run();
    wait_done(3000, ok);
    tests_run++; if (!ok) begin tests_failed++; $display("FAIL single_nack_done: got DONE=0 expected DONE=1"); end
    tests_run++; if (bus.ERROR !== 1'b0) begin tests_failed++; $display("FAIL single_nack_error: got %b expected 0", bus.ERROR); end
    tests_run++; if (att_data.size() != 5) begin tests_failed++; $display("FAIL single_nack_pulses: got %0d expected 5", att_data.size()); end
    for (int i = 0; i < 5; i++) exp_q.push_back(exp_word(exp_idx[i]));
    for (int i = 0; i < exp_q.size(); i++) begin
      tests_run++; if (att_data[i] !== exp_q[i]) begin tests_failed++; $display("FAIL single_nack_data[%0d]: got %h expected %h", i, att_data[i], exp_q[i]); end
    end
  endtask

  task automatic test_persistent_nack();
    bit ok;
    int exp_idx[7];
    exp_idx = '{0, 1, 1, 1, 1, 2, 3};
    nack_idx = 1; nack_val = 3'b100; nack_always = 1'b1; noend_idx = -1;
    start_run();
    wait_done(3000, ok);
    tests_run++; if (!ok) begin tests_failed++; $display("FAIL persist_done: got DONE=0 expected DONE=1"); end
    tests_run++; if (bus.ERROR !== 1'b1) begin tests_failed++; $display("FAIL persist_error: got %b expected 1", bus.ERROR); end
    tests_run++; if (bus.ERR_INDEX !== 4'd1) begin tests_failed++; $display("FAIL persist_err_index: got %0d expected 1", bus.ERR_INDEX); end
    tests_run++; if (att_idx.size() != 7) begin tests_failed++; $display("FAIL persist_pulses: got %0d expected 7", att_idx.size()); end
    for (int i = 0; i < 7; i++) exp_q.push_back(exp_word(exp_idx[i]));
    for (int i = 0; i < exp_q.size(); i++) begin
      tests_run++; if (att_data[i] !== exp_q[i]) begin tests_failed++; $display("FAIL persist_data[%0d]: got %h expected %h", i, att_data[i], exp_q[i]); end
    end
  endtask

  task automatic test_timeout();
    bit ok;
    int exp_idx[7];
    exp_idx = '{0, 0, 0, 0, 1, 2, 3};
    nack_idx = -1; noend_idx = 0;
    start_run();
    wait_done(3000, ok);
    tests_run++; if (!ok) begin tests_failed++; $display("FAIL timeout_done: got DONE=0 expected DONE=1"); end
    tests_run++; if (bus.ERROR !== 1'b1) begin tests_failed++; $display("FAIL timeout_error: got %b expected 1", bus.ERROR); end
    tests_run++; if (bus.ERR_INDEX !== 4'd0) begin tests_failed++; $display("FAIL timeout_err_index: got %0d expected 0", bus.ERR_INDEX); end
    tests_run++; if (att_idx.size() != 7) begin tests_failed++; $display("FAIL timeout_pulses: got %0d expected 7", att_idx.size()); end
    for (int i = 0; i < 7; i++) exp_q.push_back(exp_word(exp_idx[i]));
    for (int i = 0; i < exp_q.size(); i++) begin
      tests_run++; if (att_data[i] !== exp_q[i]) begin tests_failed++; $display("FAIL timeout_data[%0d]: got %h expected %h", i, att_data[i], exp_q[i]); end
    end
    // GO stays high for the full XFER window plus the CHECK cycle.
    for (int i = 0; i < 4; i++) begin
      tests_run++; if (att_len[i] != XFER_TIMEOUT + 1) begin tests_failed++; $display("FAIL timeout_go_len[%0d]: got %0d expected %0d", i, att_len[i], XFER_TIMEOUT + 1); end
    end
  endtask

  task automatic test_restart_ignore();
    int cyc;
    bit seen, ok;
    nack_idx = -1; noend_idx = -1;
    @(negedge clk);
    clear_logs();
    bus.START = 1'b1;
    @(negedge clk);
    bus.START = 1'b0;
    tests_run++; if (bus.DONE !== 1'b0) begin tests_failed++; $display("FAIL restart_done: got %b expected 0", bus.DONE); end
    tests_run++; if (bus.ERROR !== 1'b0) begin tests_failed++; $display("FAIL restart_error: got %b expected 0", bus.ERROR); end
    tests_run++; if (bus.ERR_INDEX !== 4'd0) begin tests_failed++; $display("FAIL restart_err_index: got %0d expected 0", bus.ERR_INDEX); end
    tests_run++; if (bus.LUT_INDEX !== 4'd0) begin tests_failed++; $display("FAIL restart_lut_index: got %0d expected 0", bus.LUT_INDEX); end
    tests_run++; if (bus.BUSY !== 1'b1) begin tests_failed++; $display("FAIL restart_busy: got %b expected 1", bus.BUSY); end
    wait_go(50, cyc, seen);
    cyc = cyc + 1;
    tests_run++; if (!seen || cyc > GO_LOW_CYCLES + 1) begin tests_failed++; $display("FAIL restart_first_go: got %0d cycles (seen=%0b) expected <= %0d", cyc, seen, GO_LOW_CYCLES + 1); end
    repeat (5) @(negedge clk);
    bus.START = 1'b1;
    repeat (5) @(negedge clk);
    bus.START = 1'b0;
    wait_done(2000, ok);
    tests_run++; if (!ok) begin tests_failed++; $display("FAIL restart_run_done: got DONE=0 expected DONE=1"); end
    tests_run++; if (bus.ERROR !== 1'b0) begin tests_failed++; $display("FAIL restart_run_error: got %b expected 0", bus.ERROR); end
    tests_run++; if (att_data.size() != 4) begin tests_failed++; $display("FAIL restart_pulses: got %0d expected 4", att_data.size()); end
    for (int i = 0; i < 4; i++) exp_q.push_back(exp_word(i));
    for (int i = 0; i < exp_q.size(); i++) begin
      tests_run++; if (att_data[i] !== exp_q[i]) begin tests_failed++; $display("FAIL restart_data[%0d]: got %h expected %h", i, att_data[i], exp_q[i]); end
    end
  endtask

  task automatic test_mid_reset();
    int cyc;
    bit seen, ok;
    nack_idx = -1; noend_idx = -1;
    start_run();
    seen = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (bus.I2C_GO && bus.LUT_INDEX == 4'd2) begin
        seen = 1'b1;
        break;
      end
    end
    tests_run++; if (!seen) begin tests_failed++; $display("FAIL midreset_reach_idx2: got no index-2 transfer expected one within 1000 cycles"); end
    repeat (5) @(negedge clk);
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    tests_run++; if (bus.I2C_GO !== 1'b0) begin tests_failed++; $display("FAIL midreset_go: got %b expected 0", bus.I2C_GO); end
    tests_run++; if (bus.BUSY !== 1'b1) begin tests_failed++; $display("FAIL midreset_busy: got %b expected 1", bus.BUSY); end
    tests_run++; if (bus.LUT_INDEX !== 4'd0) begin tests_failed++; $display("FAIL midreset_lut_index: got %0d expected 0", bus.LUT_INDEX); end
    tests_run++; if (bus.I2C_DATA !== 24'h0) begin tests_failed++; $display("FAIL midreset_i2c_data: got %h expected 000000", bus.I2C_DATA); end
    tests_run++; if (bus.DONE !== 1'b0 || bus.ERROR !== 1'b0) begin tests_failed++; $display("FAIL midreset_status: got DONE=%b ERROR=%b expected 0 0", bus.DONE, bus.ERROR); end
    repeat (2) @(negedge clk);
    clear_logs();
    rst_n = 1'b1;
    wait_go(200, cyc, seen);
    tests_run++; if (!seen || cyc < INIT_DELAY + GO_LOW_CYCLES) begin tests_failed++; $display("FAIL midreset_first_go: got %0d cycles (seen=%0b) expected >= %0d", cyc, seen, INIT_DELAY + GO_LOW_CYCLES); end
    wait_done(2000, ok);
    tests_run++; if (!ok) begin tests_failed++; $display("FAIL midreset_done: got DONE=0 expected DONE=1"); end
    tests_run++; if (att_idx.size() != 4) begin tests_failed++; $display("FAIL midreset_pulses: got %0d expected 4", att_idx.size()); end
    for (int i = 0; i < 4; i++) exp_q.push_back(exp_word(i));
    for (int i = 0; i < exp_q.size(); i++) begin
      tests_run++; if (att_data[i] !== exp_q[i]) begin tests_failed++; $display("FAIL midreset_data[%0d]: got %h expected %h", i, att_data[i], exp_q[i]); end
    end
  endtask

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: got simulation still running expected completion before 1ms");
    $fatal(1, "watchdog expired");
  end

  initial begin
    for (int i = 0; i < 16; i++) lut_tab[i] = 16'hFFFF;
    lut_tab[0] = 16'h0297;
    lut_tab[1] = 16'h0497;
    lut_tab[2] = 16'h0879;
    lut_tab[3] = 16'h0A00;
    bus.START = 1'b0;
    test_reset();
    test_nominal();
    test_single_nack();
    test_persistent_nack();
    test_timeout();
    test_restart_ignore();
    test_mid_reset();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
